// File: rtl/pong_game_ctrl_if.sv
// Game-side bundle of the pong controller: frame pulse and buttons in, playfield state out.
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic [3:0] btns;
    logic [8:0] pad1_y;
    logic [8:0] pad2_y;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       game_over;
    logic       busy;

    modport master (
        output frame_tick, btns,
        input  pad1_y, pad2_y, ball_x, ball_y, score1, score2, game_over, busy
    );

    modport slave (
        input  frame_tick, btns,
        output pad1_y, pad2_y, ball_x, ball_y, score1, score2, game_over, busy
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game controller: per-frame paddle/ball update sequence, collision, scoring and serve.
// Game mode (SERVE/PLAY/GAME_OVER) and the four-phase update sequence share one FSM pair.
module pong_game_ctrl #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int PAD_H      = 64,
    parameter int PAD_W      = 8,
    parameter int PAD_STEP   = 4,
    parameter int BALL_STEP  = 2,
    parameter int BALL_W     = 8,
    parameter int P1_X       = 16,
    parameter int P2_X       = 616,
    parameter int WIN        = 9,
    parameter int SERVE_WAIT = 60
) (
    input  logic            CLK,
    input  logic            rst_n,
    pong_game_ctrl_if.slave game_if
);

    typedef enum logic [1:0] {
        PH_IDLE     = 2'd0,
        PH_UPD_PAD  = 2'd1,
        PH_UPD_BALL = 2'd2,
        PH_CHECK    = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        MODE_SERVE     = 2'd0,
        MODE_PLAY      = 2'd1,
        MODE_GAME_OVER = 2'd2
    } mode_e;

    localparam int               CNT_W      = $clog2(SERVE_WAIT + 2);
    localparam logic [CNT_W-1:0] SERVE_INIT = CNT_W'(SERVE_WAIT);
    localparam logic [CNT_W-1:0] SERVE_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] SERVE_ZERO = CNT_W'(0);
    localparam logic [9:0]  PAD_MAX    = 10'(V_RES - PAD_H);
    localparam logic [8:0]  PAD_MAX_9  = 9'(V_RES - PAD_H);
    localparam logic [9:0]  PAD_STEP_L = 10'(PAD_STEP);
    localparam logic [8:0]  PAD_STEP_9 = 9'(PAD_STEP);
    localparam logic [9:0]  PAD_H_L    = 10'(PAD_H);
    localparam logic [8:0]  PAD_CTR    = 9'((V_RES - PAD_H) / 2);
    localparam logic [9:0]  Y_STEP     = 10'(BALL_STEP);
    localparam logic [8:0]  Y_STEP_9   = 9'(BALL_STEP);
    localparam logic [9:0]  Y_MAX      = 10'(V_RES - BALL_W);
    localparam logic [8:0]  Y_MAX_9    = 9'(V_RES - BALL_W);
    localparam logic [9:0]  BW_Y       = 10'(BALL_W);
    localparam logic [8:0]  Y_CTR      = 9'((V_RES - BALL_W) / 2);
    localparam logic [10:0] X_STEP     = 11'(BALL_STEP);
    localparam logic [9:0]  X_STEP_10  = 10'(BALL_STEP);
    localparam logic [10:0] X_MAX      = 11'(H_RES - BALL_W);
    localparam logic [9:0]  X_MAX_10   = 10'(H_RES - BALL_W);
    localparam logic [10:0] BW_X       = 11'(BALL_W);
    localparam logic [9:0]  X_CTR      = 10'((H_RES - BALL_W) / 2);
    localparam logic [10:0] P1_LEFT    = 11'(P1_X);
    localparam logic [10:0] P1_RIGHT   = 11'(P1_X + PAD_W);
    localparam logic [10:0] P2_LEFT    = 11'(P2_X);
    localparam logic [10:0] P2_RIGHT   = 11'(P2_X + PAD_W);
    localparam logic [9:0]  P1_BOUNCE  = 10'(P1_X + PAD_W);
    localparam logic [9:0]  P2_BOUNCE  = 10'(P2_X - BALL_W);
    localparam logic [3:0]  WIN_S      = 4'(WIN);
    localparam logic [3:0]  WIN_M1     = 4'(WIN - 1);

    phase_e           phase_q, phase_d;
    mode_e            mode_q, mode_d;
    logic [8:0]       pad1_q, pad1_d, pad2_q, pad2_d;
    logic [9:0]       ball_x_q, ball_x_d;
    logic [8:0]       ball_y_q, ball_y_d;
    logic             dx_pos_q, dx_pos_d, dy_pos_q, dy_pos_d;
    logic [3:0]       score1_q, score1_d, score2_q, score2_d;
    logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
    logic             goal1_q, goal1_d, goal2_q, goal2_d;
    logic             restart_q, restart_d;
    logic             busy_q, busy_d, game_over_q, game_over_d;

    logic [10:0] bx_ext_s, x_fwd_s;
    logic [9:0]  x_back_s;
    logic [9:0]  by_ext_s, y_fwd_s, pad1_ext_s, pad2_ext_s;
    logic [8:0]  y_back_s;
    logic        rows1_s, rows2_s, hit1_s, hit2_s;

    // Step is clamped against the limits before being applied, so the stored value never wraps.
    function automatic logic [8:0] pad_next(input logic [8:0] y, input logic up, input logic dn);
        logic [9:0] y_ext;
        logic [9:0] y_inc;
        logic [8:0] r;
        y_ext = {1'b0, y};
        y_inc = y_ext + PAD_STEP_L;
        if (up && !dn) begin
            if (y_ext < PAD_STEP_L) begin
                r = 9'd0;
            end else begin
                r = y - PAD_STEP_9;
            end
        end else if (dn && !up) begin
            if (y_inc > PAD_MAX) begin
                r = PAD_MAX_9;
            end else begin
                r = y_inc[8:0];
            end
        end else begin
            r = y;
        end
        return r;
    endfunction

    assign bx_ext_s   = {1'b0, ball_x_q};
    assign by_ext_s   = {1'b0, ball_y_q};
    assign pad1_ext_s = {1'b0, pad1_q};
    assign pad2_ext_s = {1'b0, pad2_q};
    assign x_fwd_s    = bx_ext_s + X_STEP;
    assign x_back_s   = ball_x_q - X_STEP_10;
    assign y_fwd_s    = by_ext_s + Y_STEP;
    assign y_back_s   = ball_y_q - Y_STEP_9;
    assign rows1_s    = (by_ext_s + BW_Y > pad1_ext_s) && (by_ext_s < pad1_ext_s + PAD_H_L);
    assign rows2_s    = (by_ext_s + BW_Y > pad2_ext_s) && (by_ext_s < pad2_ext_s + PAD_H_L);
    assign hit1_s     = !dx_pos_q && (bx_ext_s <= P1_RIGHT) && (bx_ext_s + BW_X > P1_LEFT) && rows1_s;
    assign hit2_s     = dx_pos_q && (bx_ext_s + BW_X >= P2_LEFT) && (bx_ext_s < P2_RIGHT) && rows2_s;

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            phase_q     <= PH_IDLE;
            mode_q      <= MODE_SERVE;
            pad1_q      <= PAD_CTR;
            pad2_q      <= PAD_CTR;
            ball_x_q    <= X_CTR;
            ball_y_q    <= Y_CTR;
            dx_pos_q    <= 1'b1;
            dy_pos_q    <= 1'b1;
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            serve_cnt_q <= SERVE_INIT;
            goal1_q     <= 1'b0;
            goal2_q     <= 1'b0;
            restart_q   <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            mode_q      <= mode_d;
            pad1_q      <= pad1_d;
            pad2_q      <= pad2_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_pos_q    <= dx_pos_d;
            dy_pos_q    <= dy_pos_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            serve_cnt_q <= serve_cnt_d;
            goal1_q     <= goal1_d;
            goal2_q     <= goal2_d;
            restart_q   <= restart_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    // Next-state logic for the update sequence and game mode.
    always_comb begin
        phase_d     = phase_q;
        mode_d      = mode_q;
        pad1_d      = pad1_q;
        pad2_d      = pad2_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_pos_d    = dx_pos_q;
        dy_pos_d    = dy_pos_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        serve_cnt_d = serve_cnt_q;
        goal1_d     = goal1_q;
        goal2_d     = goal2_q;
        restart_d   = restart_q;

        case (phase_q)
            PH_IDLE: begin
                if (game_if.frame_tick) begin
                    phase_d   = PH_UPD_PAD;
                    restart_d = (mode_q == MODE_GAME_OVER) && (game_if.btns != 4'b0000);
                end else begin
                    phase_d = PH_IDLE;
                end
            end
            PH_UPD_PAD: begin
                phase_d = PH_UPD_BALL;
                if (mode_q != MODE_GAME_OVER) begin
                    pad1_d = pad_next(pad1_q, game_if.btns[3], game_if.btns[2]);
                    pad2_d = pad_next(pad2_q, game_if.btns[1], game_if.btns[0]);
                end else begin
                    pad1_d = pad1_q;
                    pad2_d = pad2_q;
                end
            end
            PH_UPD_BALL: begin
                phase_d = PH_CHECK;
                if (mode_q == MODE_SERVE) begin
                    if (serve_cnt_q != SERVE_ZERO) begin
                        serve_cnt_d = serve_cnt_q - SERVE_ONE;
                    end else begin
                        serve_cnt_d = serve_cnt_q;
                    end
                end else if (mode_q == MODE_PLAY) begin
                    if (!dy_pos_q) begin
                        if (by_ext_s < Y_STEP) begin
                            ball_y_d = 9'd0;
                            dy_pos_d = 1'b1;
                        end else begin
                            ball_y_d = y_back_s;
                        end
                    end else if (y_fwd_s >= Y_MAX) begin
                        ball_y_d = Y_MAX_9;
                        dy_pos_d = 1'b0;
                    end else begin
                        ball_y_d = y_fwd_s[8:0];
                    end
                    // Reaching an outer wall only flags the goal; CHECK decides if a paddle saved it.
                    if (!dx_pos_q) begin
                        if (bx_ext_s < X_STEP) begin
                            ball_x_d = 10'd0;
                            goal2_d  = 1'b1;
                        end else begin
                            ball_x_d = x_back_s;
                        end
                    end else if (x_fwd_s >= X_MAX) begin
                        ball_x_d = X_MAX_10;
                        goal1_d  = 1'b1;
                    end else begin
                        ball_x_d = x_fwd_s[9:0];
                    end
                end else begin
                    serve_cnt_d = serve_cnt_q;
                end
            end
            PH_CHECK: begin
                phase_d   = PH_IDLE;
                goal1_d   = 1'b0;
                goal2_d   = 1'b0;
                restart_d = 1'b0;
                if ((mode_q == MODE_PLAY) && hit1_s) begin
                    dx_pos_d = 1'b1;
                    ball_x_d = P1_BOUNCE;
                end else if ((mode_q == MODE_PLAY) && hit2_s) begin
                    dx_pos_d = 1'b0;
                    ball_x_d = P2_BOUNCE;
                end else if ((mode_q == MODE_PLAY) && (goal1_q || goal2_q)) begin
                    ball_x_d    = X_CTR;
                    ball_y_d    = Y_CTR;
                    serve_cnt_d = SERVE_INIT;
                    if (goal1_q) begin
                        dx_pos_d = 1'b1;
                        if (score1_q >= WIN_M1) begin
                            score1_d = WIN_S;
                            mode_d   = MODE_GAME_OVER;
                        end else begin
                            score1_d = score1_q + 4'd1;
                            mode_d   = MODE_SERVE;
                        end
                    end else begin
                        dx_pos_d = 1'b0;
                        if (score2_q >= WIN_M1) begin
                            score2_d = WIN_S;
                            mode_d   = MODE_GAME_OVER;
                        end else begin
                            score2_d = score2_q + 4'd1;
                            mode_d   = MODE_SERVE;
                        end
                    end
                end else if ((mode_q == MODE_SERVE) && (serve_cnt_q == SERVE_ZERO)) begin
                    mode_d = MODE_PLAY;
                end else if ((mode_q == MODE_GAME_OVER) && restart_q) begin
                    score1_d    = 4'd0;
                    score2_d    = 4'd0;
                    ball_x_d    = X_CTR;
                    ball_y_d    = Y_CTR;
                    serve_cnt_d = SERVE_INIT;
                    mode_d      = MODE_SERVE;
                end else begin
                    mode_d = mode_q;
                end
            end
            default: begin
                phase_d = PH_IDLE;
            end
        endcase

        busy_d      = (phase_d != PH_IDLE);
        game_over_d = (mode_d == MODE_GAME_OVER);
    end

    assign game_if.pad1_y    = pad1_q;
    assign game_if.pad2_y    = pad2_q;
    assign game_if.ball_x    = ball_x_q;
    assign game_if.ball_y    = ball_y_q;
    assign game_if.score1    = score1_q;
    assign game_if.score2    = score2_q;
    assign game_if.game_over = game_over_q;
    assign game_if.busy      = busy_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: serve timing, paddle limits, bounces, scoring, game over, reset.
module tb_pong_game_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    pong_game_ctrl_if gif ();

    pong_game_ctrl dut (
        .CLK     (clk),
        .rst_n   (rst_n),
        .game_if (gif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        gif.frame_tick = 1'b0;
        gif.btns       = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One frame: pulse, then wait out the three busy cycles; ends at a negedge with phase IDLE.
    task automatic tick(input logic [3:0] b);
        @(negedge clk);
        gif.btns       = b;
        gif.frame_tick = 1'b1;
        @(negedge clk);
        gif.frame_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic ticks(input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++) tick(b);
    endtask

    initial begin
        rst_n          = 1'b0;
        gif.frame_tick = 1'b0;
        gif.btns       = 4'b0000;

        // Reset state and serve delay
        do_reset();
        chk("rst_pad1", gif.pad1_y, 208);
        chk("rst_pad2", gif.pad2_y, 208);
        chk("rst_ball_x", gif.ball_x, 316);
        chk("rst_ball_y", gif.ball_y, 236);
        chk("rst_score1", gif.score1, 0);
        chk("rst_score2", gif.score2, 0);
        chk("rst_game_over", gif.game_over, 0);
        chk("rst_busy", gif.busy, 0);
        ticks(59, 4'b0000);
        chk("serve59_ball_x", gif.ball_x, 316);
        tick(4'b0000);
        chk("serve60_ball_x", gif.ball_x, 316);
        chk("serve60_ball_y", gif.ball_y, 236);

        // 61st tick held high for three cycles: busy profile and no re-trigger
        @(negedge clk);
        gif.frame_tick = 1'b1;
        gif.btns       = 4'b0000;
        chk("busy_pre", gif.busy, 0);
        @(negedge clk);
        chk("busy_pad", gif.busy, 1);
        @(negedge clk);
        chk("busy_ball", gif.busy, 1);
        chk("play_x_before_ball", gif.ball_x, 316);
        @(negedge clk);
        gif.frame_tick = 1'b0;
        chk("busy_check", gif.busy, 1);
        chk("play_x_after_ball", gif.ball_x, 318);
        @(negedge clk);
        chk("busy_done", gif.busy, 0);
        @(negedge clk);
        chk("busy_no_queue", gif.busy, 0);
        chk("play61_ball_x", gif.ball_x, 318);
        chk("play61_ball_y", gif.ball_y, 238);

        // Paddle movement and clamping
        do_reset();
        ticks(51, 4'b1000);
        chk("pad1_up51", gif.pad1_y, 4);
        tick(4'b1000);
        chk("pad1_up52", gif.pad1_y, 0);
        ticks(8, 4'b1000);
        chk("pad1_up60", gif.pad1_y, 0);
        chk("pad2_idle", gif.pad2_y, 208);
        tick(4'b0100);
        chk("pad1_down", gif.pad1_y, 4);
        tick(4'b1100);
        chk("pad1_both", gif.pad1_y, 4);
        tick(4'b0011);
        chk("pad2_both", gif.pad2_y, 208);

        // Reset while in UPD_BALL
        do_reset();
        ticks(5, 4'b1001);
        chk("pre_rst_pad1", gif.pad1_y, 188);
        chk("pre_rst_pad2", gif.pad2_y, 228);
        @(negedge clk);
        gif.frame_tick = 1'b1;
        gif.btns       = 4'b0000;
        @(negedge clk);
        gif.frame_tick = 1'b0;
        chk("mid_busy", gif.busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", gif.busy, 0);
        chk("midrst_pad1", gif.pad1_y, 208);
        chk("midrst_pad2", gif.pad2_y, 208);
        chk("midrst_ball_x", gif.ball_x, 316);
        chk("midrst_ball_y", gif.ball_y, 236);
        chk("midrst_game_over", gif.game_over, 0);
        rst_n = 1'b1;

        // P2 returns the ball, P1 misses: goal for player 2
        ticks(48, 4'b0001);
        chk("p2_pad_at_400", gif.pad2_y, 400);
        ticks(158, 4'b0000);
        chk("p2_hit_ball_x", gif.ball_x, 608);
        chk("p2_hit_ball_y", gif.ball_y, 416);
        tick(4'b0000);
        chk("p2_ret_ball_x", gif.ball_x, 606);
        chk("p2_ret_ball_y", gif.ball_y, 414);
        ticks(303, 4'b0000);
        chk("left_wall_x", gif.ball_x, 0);
        chk("left_wall_score2", gif.score2, 0);
        tick(4'b0000);
        chk("goal2_score2", gif.score2, 1);
        chk("goal2_score1", gif.score1, 0);
        chk("goal2_ball_x", gif.ball_x, 316);
        chk("goal2_ball_y", gif.ball_y, 236);
        ticks(60, 4'b0000);
        chk("goal2_serve_x", gif.ball_x, 316);
        tick(4'b0000);
        chk("goal2_dx_left", gif.ball_x, 314);
        chk("goal2_dy_kept", gif.ball_y, 238);

        // P1 paddle hit at ball_x 26 -> 24
        do_reset();
        ticks(12, 4'b1001);
        ticks(36, 4'b0001);
        chk("p1_pad_at_160", gif.pad1_y, 160);
        chk("p1_pad2_at_400", gif.pad2_y, 400);
        ticks(449, 4'b0000);
        chk("p1_pre_x", gif.ball_x, 26);
        chk("p1_pre_y", gif.ball_y, 164);
        tick(4'b0000);
        chk("p1_hit_x", gif.ball_x, 24);
        chk("p1_hit_score1", gif.score1, 0);
        chk("p1_hit_score2", gif.score2, 0);
        tick(4'b0000);
        chk("p1_after_x", gif.ball_x, 26);
        chk("p1_after_y", gif.ball_y, 168);

        // Nine unanswered goals for player 1 -> game over, then restart
        do_reset();
        ticks(218, 4'b0000);
        chk("rally1_score1", gif.score1, 1);
        chk("rally1_score2", gif.score2, 0);
        chk("rally1_ball_x", gif.ball_x, 316);
        chk("rally1_ball_y", gif.ball_y, 236);
        chk("rally1_game_over", gif.game_over, 0);
        ticks(7 * 218, 4'b0000);
        chk("rally8_score1", gif.score1, 8);
        ticks(217, 4'b0000);
        chk("rally9_pre_x", gif.ball_x, 630);
        chk("rally9_pre_score1", gif.score1, 8);
        tick(4'b0000);
        chk("win_score1", gif.score1, 9);
        chk("win_game_over", gif.game_over, 1);
        tick(4'b0000);
        chk("idle_game_over", gif.game_over, 1);
        chk("idle_score1", gif.score1, 9);
        tick(4'b0001);
        chk("restart_score1", gif.score1, 0);
        chk("restart_score2", gif.score2, 0);
        chk("restart_game_over", gif.game_over, 0);
        chk("restart_ball_x", gif.ball_x, 316);
        chk("restart_ball_y", gif.ball_y, 236);
        chk("restart_pad2_frozen", gif.pad2_y, 208);
        tick(4'b0001);
        chk("restart_pad2_moves", gif.pad2_y, 212);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter H_RES, default 640, visible width in pixels.
REQ-002 Parameter V_RES, default 480, visible height in lines.
REQ-003 Parameter PAD_H, default 64, and PAD_W, default 8: paddle height and width.
REQ-004 Parameter PAD_STEP, default 4, and BALL_STEP, default 2: pixels moved per frame.
REQ-005 Parameter BALL_W, default 8: square ball side.
REQ-006 Parameter P1_X, default 16, and P2_X, default 616: paddle left-edge x.
REQ-007 Parameter WIN, default 9, and SERVE_WAIT, default 60: winning score and serve delay in frames.
REQ-008 CLK  input  1  the single clock; all logic on its rising edge.
REQ-009 rst_n  input  1  reset, synchronous, active-low.
REQ-010 frame_tick  input  1  one-cycle pulse at start of vertical blanking.
REQ-011 btns  input  4  {p1_up, p1_down, p2_up, p2_down}, level, active-high.
REQ-012 pad1_y, pad2_y  output  9 each  paddle top-edge y.
REQ-013 ball_x  output  10 and ball_y  output  9  ball top-left corner.
REQ-014 score1, score2  output  4 each  player scores.
REQ-015 game_over  output  1  high while in GAME_OVER.
REQ-016 busy  output  1  high during the per-frame update sequence.

Function
REQ-017 FSM states: SERVE, PLAY, GAME_OVER (mode); update phases IDLE, UPD_PAD, UPD_BALL, CHECK (sequence).
REQ-018 frame_tick while phase IDLE: next cycle UPD_PAD, then UPD_BALL, then CHECK, then IDLE; busy=1 exactly in those three cycles.
REQ-019 frame_tick while busy=1 is ignored; no queuing.
REQ-020 UPD_PAD (SERVE and PLAY only): up-only -> y=max(0, y-PAD_STEP); down-only -> y=min(V_RES-PAD_H, y+PAD_STEP); both or neither -> hold; per paddle independently.
REQ-021 UPD_BALL in SERVE: decrement serve counter; ball unchanged; counter reaching 0 -> mode PLAY at end of CHECK.
REQ-022 UPD_BALL in PLAY, vertical: dy=-1 and ball_y<BALL_STEP -> ball_y=0, dy=+1; dy=+1 and ball_y+BALL_STEP>=V_RES-BALL_W -> ball_y=V_RES-BALL_W, dy=-1; else ball_y+=dy*BALL_STEP.
REQ-023 UPD_BALL in PLAY, horizontal: dx=-1 and ball_x<BALL_STEP -> ball_x=0, flag goal2; dx=+1 and ball_x+BALL_STEP>=H_RES-BALL_W -> ball_x=H_RES-BALL_W, flag goal1; else ball_x+=dx*BALL_STEP.
REQ-024 CHECK paddle hit, P1: dx=-1, ball_x<=P1_X+PAD_W, ball_x+BALL_W>P1_X, ball_y+BALL_W>pad1_y, ball_y<pad1_y+PAD_H -> dx=+1, ball_x=P1_X+PAD_W, goal flag cleared.
REQ-025 CHECK paddle hit, P2: mirror of REQ-024 with P2_X; result dx=-1, ball_x=P2_X-BALL_W.
REQ-026 CHECK goal (no hit): scorer's score +1; ball=((H_RES-BALL_W)/2, (V_RES-BALL_W)/2); dx toward conceding player; dy unchanged; serve counter=SERVE_WAIT; mode SERVE.
REQ-027 Score reaching WIN -> mode GAME_OVER instead of SERVE; score saturates at WIN.
REQ-028 GAME_OVER: paddles and ball frozen; frame_tick with any btns bit set -> scores 0, centred ball, serve counter=SERVE_WAIT, mode SERVE, after that sequence's CHECK.
REQ-029 All arithmetic unsigned, no wrap; comparisons evaluated before update so no under/overflow is ever stored.

Reset
REQ-030 rst_n=0 at a clock edge overrides everything, including mid-sequence: mode SERVE, phase IDLE, busy=0, game_over=0.
REQ-031 Reset values: pad1_y=pad2_y=(V_RES-PAD_H)/2=208; ball_x=316, ball_y=236; dx=+1, dy=+1; score1=score2=0; serve counter=SERVE_WAIT.

Verification
REQ-032 Reset then 60 frame_ticks, no btns -> mode PLAY after 60th CHECK; on 61st tick ball_x 316->318, ball_y 236->238; busy high 3 cycles per tick.
REQ-033 btns=4'b1000 held 60 ticks from reset -> pad1_y reaches 0 on 52nd tick, stays 0; btns=4'b1100 -> pad1_y holds.
REQ-034 Ball at (26,100), dx=-1, pad1_y=80 -> after tick ball_x=24, dx=+1, no score change.
REQ-035 Ball at (1,300), dx=-1, pad1_y=0 -> score2+1, ball (316,236), dx=-1, mode SERVE.
REQ-036 score1=8, ball at (631,10), dx=+1 -> score1=9, game_over=1; later tick with btns=4'b0001 -> scores 0, game_over=0.
REQ-037 rst_n low during UPD_BALL -> next cycle all outputs at REQ-031 values, busy=0.
